// File: rtl/smith_waterman_pkg.sv
// Shared constants, types and saturating score helpers for the Smith-Waterman
// aligner. Scores are SCORE_W-bit two's complement; every add clamps to the
// representable range instead of wrapping.
package smith_waterman_pkg;

  localparam int PE_NUM  = 64;    // processing elements = s bases per chunk
  localparam int PE_LOG  = 6;     // log2(PE_NUM)
  localparam int T_MAX   = 1024;  // stored t bases, multiple of 8
  localparam int SCORE_W = 16;
  localparam int MATCH_W = 8;
  localparam int GAP_W   = 8;

  localparam int T_LOG   = $clog2(T_MAX);
  localparam int TLEN_W  = T_LOG + 1;  // holds 0..T_MAX
  localparam int CNT_W   = T_LOG + 2;  // holds t_len + PE_NUM + slack
  localparam int TWORDS  = T_MAX / 8;  // t is stored as 8-base words

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_T,
    ST_WAIT_S,
    ST_RUN,
    ST_DONE
  } sw_state_t;

  typedef logic [1:0]                base_t;
  typedef logic signed [SCORE_W-1:0] score_t;

  localparam score_t SCORE_MIN = score_t'({1'b1, {(SCORE_W-1){1'b0}}});
  localparam score_t SCORE_MAX = score_t'({1'b0, {(SCORE_W-1){1'b1}}});

  // Add with clamp: overflow shows up as disagreement of the two top bits.
  function automatic score_t sat_add(score_t a, score_t b);
    logic signed [SCORE_W:0] sum;
    sum = {a[SCORE_W-1], a} + {b[SCORE_W-1], b};
    if (sum[SCORE_W] != sum[SCORE_W-1]) return sum[SCORE_W] ? SCORE_MIN : SCORE_MAX;
    return sum[SCORE_W-1:0];
  endfunction

  function automatic score_t smax(score_t a, score_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic score_t widen_m(logic [MATCH_W-1:0] x);
    return score_t'({{(SCORE_W-MATCH_W){1'b0}}, x});
  endfunction

  function automatic score_t widen_g(logic [GAP_W-1:0] x);
    return score_t'({{(SCORE_W-GAP_W){1'b0}}, x});
  endfunction

endpackage

// File: rtl/smith_waterman_if.sv
// User-side bus of the aligner: control pulses, t/s data, score settings and
// status. master = user/bench, slave = smith_waterman.
interface smith_waterman_if;
  import smith_waterman_pkg::*;

  logic                 i_set_t;       // pulse: start loading t
  logic                 i_start_cal;   // pulse: start alignment
  logic                 o_busy;        // high outside IDLE
  logic [SCORE_W-1:0]   o_result;      // best local score, held until next o_valid
  logic                 o_valid;       // one-cycle result strobe
  logic                 o_request_s;   // ready for the next s chunk
  logic [17:0]          i_t;           // [17] valid, [16] last, [15:0] eight bases
  logic [2*PE_NUM-1:0]  i_s;           // PE_NUM bases, base 0 in [1:0]
  logic [PE_LOG:0]      i_s_valid;     // 0 none, all-ones full chunk, else final count
  logic [MATCH_W-1:0]   i_match;
  logic [MATCH_W-1:0]   i_mismatch;
  logic [GAP_W-1:0]     i_minusAlpha;  // gap open
  logic [GAP_W-1:0]     i_minusBeta;   // gap extend

  modport master (
    output i_set_t, i_start_cal, i_t, i_s, i_s_valid,
           i_match, i_mismatch, i_minusAlpha, i_minusBeta,
    input  o_busy, o_result, o_valid, o_request_s
  );

  modport slave (
    input  i_set_t, i_start_cal, i_t, i_s, i_s_valid,
           i_match, i_mismatch, i_minusAlpha, i_minusBeta,
    output o_busy, o_result, o_valid, o_request_s
  );

endinterface

// File: rtl/smith_waterman_pe.sv
// sw_pe: one systolic cell owning one s base (one matrix column). Each valid
// input carries one t row: the t base plus H/E of the left neighbour for that
// row. The cell keeps its own previous-row H/F (up) and the left neighbour's
// previous-row H (diagonal), and tracks the largest H it produced.
// Ports: load/s_base_in/active_in prime the cell for a chunk; in_* from the
// left, out_* registered to the right; max_h is this column's best H.
module sw_pe
  import smith_waterman_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  base_t              s_base_in,
  input  logic               active_in,
  input  logic               in_valid,
  input  base_t              in_t,
  input  score_t             in_h,
  input  score_t             in_e,
  input  logic [MATCH_W-1:0] match,
  input  logic [MATCH_W-1:0] mismatch,
  input  logic [GAP_W-1:0]   gap_open,
  input  logic [GAP_W-1:0]   gap_extend,
  output logic               out_valid,
  output base_t              out_t,
  output score_t             out_h,
  output score_t             out_e,
  output score_t             max_h
);

  base_t  s_base;
  logic   active;
  score_t h_up, f_up, h_diag;
  score_t diag_score, e_new, f_new, h_new;

  // NOTE: every always_comb output is assigned on every path, so no latch appears.
  always_comb begin
    diag_score = sat_add(h_diag, (in_t == s_base) ? widen_m(match) : -widen_m(mismatch));
    e_new      = smax(sat_add(in_e, -widen_g(gap_extend)), sat_add(in_h, -widen_g(gap_open)));
    f_new      = smax(sat_add(f_up, -widen_g(gap_extend)), sat_add(h_up, -widen_g(gap_open)));
    h_new      = smax(smax('0, diag_score), smax(e_new, f_new));
  end

  // NOTE: state registers use non-blocking assignment so all cells update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_base    <= '0;
      active    <= 1'b0;
      h_up      <= '0;
      f_up      <= SCORE_MIN;
      h_diag    <= '0;
      max_h     <= '0;
      out_valid <= 1'b0;
      out_t     <= '0;
      out_h     <= '0;
      out_e     <= '0;
    end else if (load) begin
      // Row -1 of the matrix: H = 0, F at minimum.
      s_base    <= s_base_in;
      active    <= active_in;
      h_up      <= '0;
      f_up      <= SCORE_MIN;
      h_diag    <= '0;
      max_h     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_t  <= in_t;
        out_h  <= h_new;
        out_e  <= e_new;
        h_up   <= h_new;
        f_up   <= f_new;
        h_diag <= in_h;
        if (active && h_new > max_h) max_h <= h_new;
      end
    end
  end

endmodule

// File: rtl/smith_waterman.sv
// smith_waterman: Gotoh local-alignment scorer. t (up to T_MAX bases) is
// stored once; s is streamed in PE_NUM-base chunks, each chunk occupying the
// PE array while t flows through it one PE per cycle. The last active column
// of each chunk is kept in a column buffer and feeds the next chunk.
// Ports: clk, rst_n (async, active low); bus = smith_waterman_if.slave.
module smith_waterman
  import smith_waterman_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  smith_waterman_if.slave  bus
);

  sw_state_t         state, state_next;
  logic [TLEN_W-1:0] t_len;
  logic [CNT_W-1:0]  cnt;        // cycles since chunk capture
  logic [T_LOG-1:0]  wr_idx;     // column buffer row being written
  logic [PE_LOG-1:0] last_pe;
  logic              final_chunk, first_chunk;
  score_t            best, chunk_max, best_next;

  logic [15:0] t_words [TWORDS];
  score_t      col_h   [T_MAX];
  score_t      col_e   [T_MAX];
  logic        feed_valid;
  base_t       feed_t;
  score_t      col_rd_h, col_rd_e;

  logic            s_take, chunk_done, busy, valid, request;
  logic [PE_LOG:0] s_n, sel_idx;

  // Values past PE_NUM other than all-ones are clamped to a full final chunk.
  assign s_take     = (state == ST_WAIT_S) && (bus.i_s_valid != '0);
  assign s_n        = (&bus.i_s_valid || bus.i_s_valid > (PE_LOG+1)'(PE_NUM))
                      ? (PE_LOG+1)'(PE_NUM) : bus.i_s_valid;
  // Last row leaves PE_NUM-1 at t_len+PE_NUM; two cycles of margin.
  assign chunk_done = (state == ST_RUN) && (cnt == CNT_W'(t_len) + CNT_W'(PE_NUM + 2));

  // PE chain: index 0 is the boundary column, k+1 is the output of PE k.
  logic   v_ch [PE_NUM+1];
  base_t  t_ch [PE_NUM+1];
  score_t h_ch [PE_NUM+1];
  score_t e_ch [PE_NUM+1];
  score_t pe_max [PE_NUM];

  assign v_ch[0] = feed_valid;
  assign t_ch[0] = feed_t;
  assign h_ch[0] = first_chunk ? '0 : col_rd_h;
  assign e_ch[0] = first_chunk ? SCORE_MIN : col_rd_e;

  for (genvar k = 0; k < PE_NUM; k++) begin : g_pe
    sw_pe u_pe (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (s_take),
      .s_base_in  (bus.i_s[2*k +: 2]),
      .active_in  ((PE_LOG+1)'(k) < s_n),
      .in_valid   (v_ch[k]),
      .in_t       (t_ch[k]),
      .in_h       (h_ch[k]),
      .in_e       (e_ch[k]),
      .match      (bus.i_match),
      .mismatch   (bus.i_mismatch),
      .gap_open   (bus.i_minusAlpha),
      .gap_extend (bus.i_minusBeta),
      .out_valid  (v_ch[k+1]),
      .out_t      (t_ch[k+1]),
      .out_h      (h_ch[k+1]),
      .out_e      (e_ch[k+1]),
      .max_h      (pe_max[k])
    );
  end

  assign sel_idx = (PE_LOG+1)'(last_pe) + (PE_LOG+1)'(1);

  always_comb begin
    chunk_max = '0;
    for (int k = 0; k < PE_NUM; k++)
      if (pe_max[k] > chunk_max) chunk_max = pe_max[k];
    best_next = smax(best, chunk_max);
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    valid      = 1'b0;
    request    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.i_set_t)          state_next = ST_LOAD_T;
        else if (bus.i_start_cal) state_next = ST_WAIT_S;
      end
      ST_LOAD_T: if (bus.i_t[17] && bus.i_t[16]) state_next = ST_IDLE;
      ST_WAIT_S: begin
        request = 1'b1;
        if (s_take) state_next = ST_RUN;
      end
      ST_RUN:  if (chunk_done) state_next = final_chunk ? ST_DONE : ST_WAIT_S;
      ST_DONE: begin
        valid      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.o_busy      = busy;
  assign bus.o_valid     = valid;
  assign bus.o_request_s = request;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_len        <= '0;
      cnt          <= '0;
      wr_idx       <= '0;
      last_pe      <= '0;
      final_chunk  <= 1'b0;
      first_chunk  <= 1'b0;
      best         <= '0;
      feed_valid   <= 1'b0;
      bus.o_result <= '0;
    end else begin
      feed_valid <= (state == ST_RUN) && (cnt < CNT_W'(t_len));
      unique case (state)
        ST_IDLE: begin
          if (bus.i_set_t) begin
            t_len <= '0;
          end else if (bus.i_start_cal) begin
            best        <= '0;
            first_chunk <= 1'b1;
          end
        end
        ST_LOAD_T: begin
          if (bus.i_t[17] && t_len < TLEN_W'(T_MAX)) t_len <= t_len + TLEN_W'(8);
        end
        ST_WAIT_S: begin
          if (s_take) begin
            cnt         <= '0;
            wr_idx      <= '0;
            last_pe     <= PE_LOG'(s_n - (PE_LOG+1)'(1));
            final_chunk <= !(&bus.i_s_valid);
          end
        end
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (v_ch[sel_idx]) wr_idx <= wr_idx + T_LOG'(1);
          if (chunk_done) begin
            best        <= best_next;
            first_chunk <= 1'b0;
            if (final_chunk) bus.o_result <= $unsigned(best_next);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD_T && bus.i_t[17] && t_len < TLEN_W'(T_MAX))
      t_words[t_len[T_LOG-1:3]] <= bus.i_t[15:0];
    // Row i is read at cycle i and rewritten by the last PE later in the same chunk.
    if (state == ST_RUN && v_ch[sel_idx]) begin
      col_h[wr_idx] <= h_ch[sel_idx];
      col_e[wr_idx] <= e_ch[sel_idx];
    end
    feed_t   <= t_words[cnt[T_LOG-1:3]][{cnt[2:0], 1'b0} +: 2];
    col_rd_h <= col_h[cnt[T_LOG-1:0]];
    col_rd_e <= col_e[cnt[T_LOG-1:0]];
  end

endmodule

// File: tb/tb_smith_waterman.sv
// Directed bench for smith_waterman: hand-scored alignments, chunk boundary,
// saturation, control-pulse priority and mid-run reset.
module tb_smith_waterman;
  import smith_waterman_pkg::*;

  typedef base_t bq_t[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   valid_pulses = 0;

  smith_waterman_if bus ();

  smith_waterman dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_valid === 1'b1) valid_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bq_t str2b(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++)
      case (s[i])
        "A":     q.push_back(2'd0);
        "C":     q.push_back(2'd1);
        "G":     q.push_back(2'd2);
        default: q.push_back(2'd3);
      endcase
    return q;
  endfunction

  function automatic logic [15:0] pack8(input bq_t b, input int w);
    logic [15:0] word;
    word = '0;
    for (int j = 0; j < 8; j++)
      if (8*w + j < b.size()) word[2*j +: 2] = b[8*w + j];
    return word;
  endfunction

  task automatic load_t(input bq_t b);
    int nw;
    nw = (b.size() + 7) / 8;
    @(negedge clk);
    bus.i_set_t = 1'b1;
    @(negedge clk);
    bus.i_set_t = 1'b0;
    for (int w = 0; w < nw; w++) begin
      bus.i_t = {1'b1, (w == nw - 1), pack8(b, w)};
      @(negedge clk);
    end
    bus.i_t = '0;
  endtask

  task automatic run_job(input bq_t s, output int res, output int chunks);
    int pos, remain, guard;
    logic [2*PE_NUM-1:0] chunk;
    pos = 0;
    chunks = 0;
    res = -1;
    @(negedge clk);
    bus.i_start_cal = 1'b1;
    @(negedge clk);
    bus.i_start_cal = 1'b0;
    do begin
      remain = s.size() - pos;
      guard = 0;
      while (bus.o_request_s !== 1'b1 && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 5000) begin
        check("request_timeout", 0, 1);
        return;
      end
      chunk = '0;
      for (int j = 0; j < PE_NUM; j++)
        if (pos + j < s.size()) chunk[2*j +: 2] = s[pos + j];
      bus.i_s       = chunk;
      bus.i_s_valid = (remain > PE_NUM) ? '1 : (PE_LOG+1)'(remain);
      @(negedge clk);
      bus.i_s_valid = '0;
      pos += PE_NUM;
      chunks++;
    end while (remain > PE_NUM);
    guard = 0;
    while (bus.o_valid !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      check("valid_timeout", 0, 1);
      return;
    end
    res = int'(bus.o_result);
  endtask

  task automatic do_job(input string tag, input bq_t t, input bq_t s,
                        input int exp_res, input int exp_chunks);
    int res, chunks, p0;
    if (t.size() > 0) load_t(t);
    p0 = valid_pulses;
    run_job(s, res, chunks);
    check({tag, "_result"}, res, exp_res);
    check({tag, "_chunks"}, chunks, exp_chunks);
    @(negedge clk);
    check({tag, "_busy_after"}, bus.o_busy, 0);
    repeat (3) @(negedge clk);
    check({tag, "_pulses"}, valid_pulses - p0, 1);
    check({tag, "_hold"}, bus.o_result, exp_res);
  endtask

  initial begin
    bq_t empty, s_long, t_span, t_sat, s_sat;
    int p0;

    bus.i_set_t      = 1'b0;
    bus.i_start_cal  = 1'b0;
    bus.i_t          = '0;
    bus.i_s          = '0;
    bus.i_s_valid    = '0;
    bus.i_match      = 8'd2;
    bus.i_mismatch   = 8'd1;
    bus.i_minusAlpha = 8'd2;
    bus.i_minusBeta  = 8'd1;

    repeat (3) @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_result", bus.o_result, 0);
    check("rst_request", bus.o_request_s, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty t after reset: chunk consumed, score 0.
    do_job("tlen0", empty, str2b("ACGT"), 0, 1);
    do_job("acgt", str2b("ACGTAAAA"), str2b("ACGT"), 8, 1);
    do_job("nomatch", str2b("AAAAAAAA"), str2b("CCCC"), 0, 1);
    do_job("gap", str2b("ACGTACGT"), str2b("ACGACGT"), 12, 1);
    do_job("mism", str2b("ACGTAAAA"), str2b("AGGT"), 5, 1);

    // 100-base s in two chunks; t = s[30..69] straddles the chunk boundary.
    for (int j = 0; j < 100; j++) s_long.push_back(base_t'((j*5 + j/7) % 4));
    for (int j = 30; j < 70; j++) t_span.push_back(s_long[j]);
    do_job("span", t_span, s_long, 80, 2);

    // 200 matches of 255 exceed the score range; extra t words beyond T_MAX are dropped.
    bus.i_match = 8'd255;
    for (int j = 0; j < T_MAX + 16; j++) t_sat.push_back(2'd0);
    for (int j = 0; j < 200; j++) s_sat.push_back(2'd0);
    do_job("sat", t_sat, s_sat, 32767, 4);
    bus.i_match = 8'd2;

    // i_start_cal while loading t has no effect.
    @(negedge clk);
    bus.i_set_t = 1'b1;
    @(negedge clk);
    bus.i_set_t     = 1'b0;
    bus.i_start_cal = 1'b1;
    bus.i_t         = '0;
    @(negedge clk);
    bus.i_start_cal = 1'b0;
    bus.i_t         = {2'b11, pack8(str2b("ACGTAAAA"), 0)};
    @(negedge clk);
    bus.i_t = '0;
    check("ld_start_busy", bus.o_busy, 0);
    check("ld_start_request", bus.o_request_s, 0);
    do_job("after_ld", empty, str2b("ACGT"), 8, 1);

    // Both pulses together in IDLE: the t load wins and t is replaced.
    @(negedge clk);
    bus.i_set_t     = 1'b1;
    bus.i_start_cal = 1'b1;
    @(negedge clk);
    bus.i_set_t     = 1'b0;
    bus.i_start_cal = 1'b0;
    check("both_request", bus.o_request_s, 0);
    check("both_busy", bus.o_busy, 1);
    bus.i_t = {2'b11, pack8(str2b("AAAAAAAA"), 0)};
    @(negedge clk);
    bus.i_t = '0;
    check("both_done_busy", bus.o_busy, 0);
    do_job("both", empty, str2b("CCCC"), 0, 1);

    // Reset in the middle of a run abandons the job.
    load_t(str2b("ACGTACGT"));
    @(negedge clk);
    bus.i_start_cal = 1'b1;
    @(negedge clk);
    bus.i_start_cal = 1'b0;
    bus.i_s         = '0;
    bus.i_s[7:0]    = 8'b11_10_01_00;
    bus.i_s_valid   = 7'd4;
    @(negedge clk);
    bus.i_s_valid = '0;
    repeat (5) @(negedge clk);
    check("run_busy", bus.o_busy, 1);
    p0 = valid_pulses;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_valid", bus.o_valid, 0);
    check("midrst_request", bus.o_request_s, 0);
    check("midrst_result", bus.o_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("midrst_no_pulse", valid_pulses - p0, 0);
    check("midrst_idle", bus.o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/smith_waterman.md
SMITH_WATERMAN -- requirements
Module: smith_waterman

Interface
REQ-001 SHALL have parameters: PE_NUM 64 (processing elements, s bases per chunk); PE_LOG 6 (log2 PE_NUM); T_MAX 1024 (max stored t bases); SCORE_W 16 (V_E_F width); MATCH_W 8; GAP_W 8.
REQ-002 SHALL have ports: clk in 1 (sole clock); rst_n in 1 (asynchronous, active-low reset).
REQ-003 i_set_t in 1 -- pulse: begin loading query t.
REQ-004 i_start_cal in 1 -- pulse: begin alignment of streamed s against stored t.
REQ-005 o_busy out 1 -- high during t load or calculation.
REQ-006 o_result out SCORE_W -- best local alignment score (unsigned).
REQ-007 o_valid out 1 -- one-cycle strobe qualifying o_result.
REQ-008 o_request_s out 1 -- level: ready to accept the next s chunk.
REQ-009 i_t in 18 -- t word: [17] valid, [16] last, [15:0] eight 2-bit bases, base 0 in [1:0].
REQ-010 i_s in 128 -- 64 2-bit bases, base 0 in [1:0].
REQ-011 i_s_valid in PE_LOG+1 -- 0: no chunk; all-ones: full 64-base chunk, more follow; 1..64: final chunk with that many bases.
REQ-012 i_match, i_mismatch in MATCH_W; i_minusAlpha, i_minusBeta in GAP_W -- unsigned magnitudes: match bonus, mismatch penalty, gap-open penalty, gap-extend penalty.

Function
REQ-013 States IDLE, LOAD_T, WAIT_S, RUN, DONE; o_busy=1 in all but IDLE.
REQ-014 IDLE: i_set_t -> LOAD_T, t length cleared; else i_start_cal -> WAIT_S; both high same cycle: i_set_t wins; both ignored outside IDLE.
REQ-015 LOAD_T: each cycle with i_t[17]=1 appends 8 bases; bases past T_MAX dropped; i_t[17]=0 words ignored; word with [17]=1 and [16]=1 appended then -> IDLE.
REQ-016 WAIT_S: o_request_s=1; i_s_valid!=0 captures chunk (count n=64 or i_s_valid), o_request_s drops next cycle, -> RUN; i_s_valid!=0 outside WAIT_S ignored.
REQ-017 RUN: PE k (k<n) holds s base k; t bases stream through array one PE per cycle (systolic); PEs k>=n inactive.
REQ-018 Recurrences (Gotoh), saturating at 0 for H, SCORE_W-bit signed internal: E=max(E_left-beta, H_left-alpha); F=max(F_up-beta, H_up-alpha); H=max(0, H_diag+(t==s ? match : -mismatch), E, F).
REQ-019 Boundary column for chunk 0 is H=0, E/F at minimum; for later chunks, H and E of the previous chunk's last active PE per t row, held in a T_MAX-entry column buffer.
REQ-020 Running maximum of all H across all chunks, cleared on i_start_cal acceptance.
REQ-021 A chunk completes no later than t_len+PE_NUM+8 cycles after capture; then full chunk -> WAIT_S, final chunk -> DONE.
REQ-022 DONE: o_result=max, o_valid=1 for exactly one cycle, -> IDLE (o_busy=0 next cycle); o_result holds until next o_valid.
REQ-023 t length 0: chunks still consumed; result 0.
REQ-024 Arithmetic saturates, never wraps; score inputs sampled per cycle, held constant by user during RUN.

Reset
REQ-025 rst_n low asynchronously forces IDLE, all outputs 0, t length 0, max 0, column buffer contents don't-care; mid-operation reset abandons the job, no o_valid.

Structure
REQ-026 Shared package holds PE_NUM, PE_LOG, T_MAX, SCORE_W, MATCH_W, GAP_W, state encoding.
REQ-027 One sub-module sw_pe (one cell: base register, H/E/F registers, max tracking), instantiated PE_NUM times; control, t store, column buffer in top.

Verification
REQ-028 Load t=ACGT (one word, valid+last), s=ACGT final chunk n=4, match 2, mismatch 1, alpha 2, beta 1 -> o_result=8, one o_valid pulse.
REQ-029 t=AAAA, s=CCCC n=4 -> o_result=0.
REQ-030 s length 100 (chunk all-ones, then i_s_valid=36), t equal to s bases 30..69 spanning boundary -> o_result=80 (40 matches x2), two request cycles.
REQ-031 t=ACGTACGT, s=ACGACGT (gap), match 2 mismatch 1 alpha 2 beta 1 -> o_result=12.
REQ-032 Assert rst_n low in RUN -> o_busy=0, o_valid never pulses; i_start_cal during LOAD_T ignored; i_set_t and i_start_cal together in IDLE -> LOAD_T.
